// File: rtl/pipe_ctrl.sv
// Five-stage in-order pipeline handshake controller: per-stage valid flops,
// over/allow_in handshakes, branch/exception flushes and performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             fetch_valid_i,
    input  logic             id_ready_i,
    input  logic             ex_ready_i,
    input  logic             mem_ready_i,
    input  logic             wb_ready_i,
    input  logic             br_flush_i,
    input  logic             exc_flush_i,
    output logic             ctl_if_over_o,
    output logic             ctl_id_over_o,
    output logic             ctl_ex_over_o,
    output logic             ctl_mem_over_o,
    output logic             ctl_wb_over_o,
    output logic             ctl_id_allow_in_o,
    output logic             ctl_ex_allow_in_o,
    output logic             ctl_mem_allow_in_o,
    output logic             ctl_wb_allow_in_o,
    output logic             id_valid_o,
    output logic             ex_valid_o,
    output logic             mem_valid_o,
    output logic             wb_valid_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    logic v_id, v_ex, v_mem, v_wb;
    logic tr_if_id, tr_id_ex, tr_ex_mem, tr_mem_wb;
    logic stall_inc, retire_inc;

    assign ctl_if_over_o  = fetch_valid_i;
    assign ctl_id_over_o  = v_id  & id_ready_i;
    assign ctl_ex_over_o  = v_ex  & ex_ready_i;
    assign ctl_mem_over_o = v_mem & mem_ready_i;
    assign ctl_wb_over_o  = v_wb  & wb_ready_i;

    // Back-pressure ripples from WB toward ID within a single cycle.
    assign ctl_wb_allow_in_o  = !v_wb  | wb_ready_i;
    assign ctl_mem_allow_in_o = !v_mem | (ctl_mem_over_o & ctl_wb_allow_in_o);
    assign ctl_ex_allow_in_o  = !v_ex  | (ctl_ex_over_o  & ctl_mem_allow_in_o);
    assign ctl_id_allow_in_o  = !v_id  | (ctl_id_over_o  & ctl_ex_allow_in_o);

    // Flushes only gate the flop updates; the handshake outputs stay untouched.
    assign tr_if_id  = ctl_if_over_o  & ctl_id_allow_in_o  & !br_flush_i & !exc_flush_i;
    assign tr_id_ex  = ctl_id_over_o  & ctl_ex_allow_in_o  & !exc_flush_i;
    assign tr_ex_mem = ctl_ex_over_o  & ctl_mem_allow_in_o & !exc_flush_i;
    assign tr_mem_wb = ctl_mem_over_o & ctl_wb_allow_in_o  & !exc_flush_i;

    assign id_valid_o  = v_id;
    assign ex_valid_o  = v_ex;
    assign mem_valid_o = v_mem;
    assign wb_valid_o  = v_wb;

    assign stall_inc  = fetch_valid_i & !ctl_id_allow_in_o;
    assign retire_inc = ctl_wb_over_o & !exc_flush_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else begin
            if (br_flush_i | exc_flush_i)                   v_id <= 1'b0;
            else if (tr_if_id)                              v_id <= 1'b1;
            else if (ctl_id_over_o & ctl_ex_allow_in_o)     v_id <= 1'b0;

            if (exc_flush_i)                                v_ex <= 1'b0;
            else if (tr_id_ex)                              v_ex <= 1'b1;
            else if (ctl_ex_over_o & ctl_mem_allow_in_o)    v_ex <= 1'b0;

            if (exc_flush_i)                                v_mem <= 1'b0;
            else if (tr_ex_mem)                             v_mem <= 1'b1;
            else if (ctl_mem_over_o & ctl_wb_allow_in_o)    v_mem <= 1'b0;

            if (tr_mem_wb)                                  v_wb <= 1'b1;
            else if (ctl_wb_over_o)                         v_wb <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cycle_cnt_o  <= '0;
            stall_cnt_o  <= '0;
            retire_cnt_o <= '0;
        end else begin
            cycle_cnt_o  <= cycle_cnt_o  + CNT_W'(1);
            stall_cnt_o  <= stall_cnt_o  + CNT_W'(stall_inc);
            retire_cnt_o <= retire_cnt_o + CNT_W'(retire_inc);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against an occupancy-array reference model; a 4-bit-counter instance covers wrap.
module tb_pipe_ctrl;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    logic fetch_valid_i = 1'b0;
    logic id_ready_i = 1'b1, ex_ready_i = 1'b1, mem_ready_i = 1'b1, wb_ready_i = 1'b1;
    logic br_flush_i = 1'b0, exc_flush_i = 1'b0;

    logic if_over, id_over, ex_over, mem_over, wb_over;
    logic id_allow, ex_allow, mem_allow, wb_allow;
    logic id_valid, ex_valid, mem_valid, wb_valid;
    logic [31:0] cycle_cnt, stall_cnt, retire_cnt;

    logic w_if_over, w_id_over, w_ex_over, w_mem_over, w_wb_over;
    logic w_id_allow, w_ex_allow, w_mem_allow, w_wb_allow;
    logic w_id_valid, w_ex_valid, w_mem_valid, w_wb_valid;
    logic [3:0] w_cycle_cnt, w_stall_cnt, w_retire_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: occupancy per stage (0=ID .. 3=WB) and counter values.
    bit [3:0]    occ;
    int unsigned m_cyc, m_stall, m_ret;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.CNT_W(32)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .fetch_valid_i(fetch_valid_i),
        .id_ready_i(id_ready_i), .ex_ready_i(ex_ready_i),
        .mem_ready_i(mem_ready_i), .wb_ready_i(wb_ready_i),
        .br_flush_i(br_flush_i), .exc_flush_i(exc_flush_i),
        .ctl_if_over_o(if_over), .ctl_id_over_o(id_over), .ctl_ex_over_o(ex_over),
        .ctl_mem_over_o(mem_over), .ctl_wb_over_o(wb_over),
        .ctl_id_allow_in_o(id_allow), .ctl_ex_allow_in_o(ex_allow),
        .ctl_mem_allow_in_o(mem_allow), .ctl_wb_allow_in_o(wb_allow),
        .id_valid_o(id_valid), .ex_valid_o(ex_valid), .mem_valid_o(mem_valid),
        .wb_valid_o(wb_valid),
        .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt), .retire_cnt_o(retire_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_w4 (
        .clk_i(clk_i), .rstn_i(rstn_i), .fetch_valid_i(fetch_valid_i),
        .id_ready_i(id_ready_i), .ex_ready_i(ex_ready_i),
        .mem_ready_i(mem_ready_i), .wb_ready_i(wb_ready_i),
        .br_flush_i(br_flush_i), .exc_flush_i(exc_flush_i),
        .ctl_if_over_o(w_if_over), .ctl_id_over_o(w_id_over), .ctl_ex_over_o(w_ex_over),
        .ctl_mem_over_o(w_mem_over), .ctl_wb_over_o(w_wb_over),
        .ctl_id_allow_in_o(w_id_allow), .ctl_ex_allow_in_o(w_ex_allow),
        .ctl_mem_allow_in_o(w_mem_allow), .ctl_wb_allow_in_o(w_wb_allow),
        .id_valid_o(w_id_valid), .ex_valid_o(w_ex_valid), .mem_valid_o(w_mem_valid),
        .wb_valid_o(w_wb_valid),
        .cycle_cnt_o(w_cycle_cnt), .stall_cnt_o(w_stall_cnt), .retire_cnt_o(w_retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: walk from WB back to ID deciding who leaves and where there is room.
    task automatic model_comb(output bit [3:0] leave, output bit [3:0] room);
        bit [3:0] rdy;
        rdy = {wb_ready_i, mem_ready_i, ex_ready_i, id_ready_i};
        for (int k = 3; k >= 0; k--) begin
            bit downstream_room;
            downstream_room = (k == 3) ? 1'b1 : room[k+1];
            leave[k] = occ[k] & rdy[k] & downstream_room;
            room[k]  = !occ[k] | leave[k];
        end
    endtask

    task automatic reset_model();
        occ = '0; m_cyc = 0; m_stall = 0; m_ret = 0;
    endtask

    // One clock: check everything at the negedge, then advance the model at the posedge.
    task automatic cyc();
        bit [3:0] leave, room, nxt;
        @(negedge clk_i);
        model_comb(leave, room);
        chk("valid", {wb_valid, mem_valid, ex_valid, id_valid}, occ);
        chk("over",  {wb_over, mem_over, ex_over, id_over, if_over},
            {occ[3] & wb_ready_i, occ[2] & mem_ready_i, occ[1] & ex_ready_i,
             occ[0] & id_ready_i, fetch_valid_i});
        chk("allow", {wb_allow, mem_allow, ex_allow, id_allow}, room);
        chk("cnt",   {cycle_cnt, stall_cnt}, {m_cyc, m_stall});
        chk("ret",   retire_cnt, m_ret);
        chk("w4cnt", {w_cycle_cnt, w_stall_cnt, w_retire_cnt},
            {m_cyc[3:0], m_stall[3:0], m_ret[3:0]});
        @(posedge clk_i);
        if (rstn_i) begin
            nxt = occ & ~leave;
            for (int k = 3; k >= 1; k--)
                if (leave[k-1] && !exc_flush_i) nxt[k] = 1'b1;
            if (fetch_valid_i && room[0] && !br_flush_i && !exc_flush_i) nxt[0] = 1'b1;
            if (exc_flush_i) nxt[2:0] = 3'b000;
            else if (br_flush_i) nxt[0] = 1'b0;
            m_cyc++;
            if (fetch_valid_i && !room[0]) m_stall++;
            if (occ[3] && wb_ready_i && !exc_flush_i) m_ret++;
            occ = nxt;
        end
        #1;
    endtask

    task automatic all_ready();
        id_ready_i = 1; ex_ready_i = 1; mem_ready_i = 1; wb_ready_i = 1;
        br_flush_i = 0; exc_flush_i = 0; fetch_valid_i = 1;
    endtask

    int unsigned snap;

    initial begin
        reset_model();
        // Reset state, before any clock edge.
        #2;
        chk("rst_valid", {wb_valid, mem_valid, ex_valid, id_valid}, 4'b0000);
        chk("rst_over",  {wb_over, mem_over, ex_over, id_over, if_over}, 5'b00000);
        chk("rst_allow", {wb_allow, mem_allow, ex_allow, id_allow}, 4'b1111);
        chk("rst_cnt",   {cycle_cnt, stall_cnt, retire_cnt}, 96'd0);
        cyc(); cyc();
        rstn_i = 1;

        // Streaming: WB fills on the 4th edge, 6 retirements after 10.
        all_ready();
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("stream_wb", wb_valid, (i >= 4));
        end
        chk("stream_retire", retire_cnt, 32'd6);
        chk("stream_cycles", cycle_cnt, 32'd10);

        // MEM back-pressure for 3 cycles with a full pipe.
        snap = stall_cnt;
        mem_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_allow", {mem_allow, ex_allow, id_allow}, 3'b000);
            cyc();
        end
        chk("bp_stall", stall_cnt - snap, 32'd3);
        mem_ready_i = 1;
        #1;
        chk("bp_resume", {mem_allow, ex_allow, id_allow}, 3'b111);
        cyc();

        // Branch flush with ID and EX occupied.
        br_flush_i = 1;
        cyc();
        br_flush_i = 0;
        chk("br_id", id_valid, 1'b0);
        chk("br_mem", mem_valid, 1'b1);

        // Exception flush with every stage occupied.
        for (int i = 0; i < 4; i++) cyc();
        snap = retire_cnt;
        exc_flush_i = 1;
        cyc();
        exc_flush_i = 0;
        chk("exc_valid", {wb_valid, mem_valid, ex_valid, id_valid}, 4'b0000);
        chk("exc_retire", retire_cnt, snap);

        // Both flushes together: exception clears dominate.
        for (int i = 0; i < 4; i++) cyc();
        exc_flush_i = 1; br_flush_i = 1;
        cyc();
        exc_flush_i = 0; br_flush_i = 0;
        chk("both_valid", {mem_valid, ex_valid, id_valid}, 3'b000);

        // Asynchronous reset mid-run, between edges.
        for (int i = 0; i < 4; i++) cyc();
        #2 rstn_i = 0;
        #1;
        chk("arst_valid", {wb_valid, mem_valid, ex_valid, id_valid}, 4'b0000);
        chk("arst_cnt",   {cycle_cnt, stall_cnt, retire_cnt}, 96'd0);
        chk("arst_allow", {wb_allow, mem_allow, ex_allow, id_allow}, 4'b1111);
        reset_model();
        cyc();
        rstn_i = 1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            fetch_valid_i = ($urandom_range(0, 3) != 0);
            id_ready_i    = ($urandom_range(0, 3) != 0);
            ex_ready_i    = ($urandom_range(0, 3) != 0);
            mem_ready_i   = ($urandom_range(0, 3) != 0);
            wb_ready_i    = ($urandom_range(0, 3) != 0);
            br_flush_i    = ($urandom_range(0, 9) == 0);
            exc_flush_i   = ($urandom_range(0, 14) == 0);
            cyc();
        end

        // 4-bit counter wraps after 16 cycles.
        all_ready();
        rstn_i = 0;
        reset_model();
        cyc();
        rstn_i = 1;
        for (int i = 0; i < 17; i++) cyc();
        chk("wrap_cycle", w_cycle_cnt, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of the performance counters.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rstn_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: fetch_valid_i  input  1  IF stage holds a fetched instruction.
REQ-005 SHALL have ports: id_ready_i, ex_ready_i, mem_ready_i, wb_ready_i  input  1 each  the stage's work completes this cycle; multi-cycle ops hold it low.
REQ-006 SHALL have port: br_flush_i  input  1  taken branch/redirect resolved in EX.
REQ-007 SHALL have port: exc_flush_i  input  1  exception or ertn committed in WB.
REQ-008 SHALL have ports: ctl_if_over_o, ctl_id_over_o, ctl_ex_over_o, ctl_mem_over_o, ctl_wb_over_o  output  1 each  stage finished and its payload is ready to leave.
REQ-009 SHALL have ports: ctl_id_allow_in_o, ctl_ex_allow_in_o, ctl_mem_allow_in_o, ctl_wb_allow_in_o  output  1 each  stage accepts a new payload this cycle.
REQ-010 SHALL have ports: id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o  output  1 each  the stage holds a live instruction.
REQ-011 SHALL have ports: cycle_cnt_o, stall_cnt_o, retire_cnt_o  output  CNT_W each  performance counters.

Function
REQ-012 SHALL keep one valid flop per stage for ID, EX, MEM and WB (v_id..v_wb); IF validity SHALL be fetch_valid_i.
REQ-013 SHALL drive ctl_X_over_o = v_X & X_ready_i; ctl_if_over_o = fetch_valid_i.
REQ-014 SHALL drive ctl_wb_allow_in_o = !v_wb | wb_ready_i.
REQ-015 SHALL drive ctl_X_allow_in_o = !v_X | (ctl_X_over_o & ctl_next_allow_in_o) for X in ID, EX, MEM.
REQ-016 SHALL define a transfer P->X as ctl_P_over_o & ctl_X_allow_in_o; on a transfer, v_X SHALL become 1 on the next edge.
REQ-017 Otherwise, if ctl_X_over_o and the next stage accepts (for WB: ctl_wb_over_o), v_X SHALL become 0; else v_X SHALL hold.
REQ-018 All outputs SHALL be combinational from the valid flops and inputs, with zero added latency: an instruction advances one stage per cycle when every ready is 1.
REQ-019 br_flush_i SHALL clear v_id on the next edge and suppress the IF->ID transfer in that cycle; EX, MEM and WB SHALL be unaffected.
REQ-020 exc_flush_i SHALL clear v_id, v_ex and v_mem on the next edge and suppress the IF->ID, ID->EX, EX->MEM and MEM->WB transfers in that cycle; v_wb SHALL follow REQ-017.
REQ-021 When exc_flush_i and br_flush_i are both high, exc_flush_i SHALL take precedence (a superset of clears).
REQ-022 Flush suppression SHALL NOT alter any ctl_*_over_o or ctl_*_allow_in_o value in the flush cycle; only the valid-flop updates change.
REQ-023 cycle_cnt_o SHALL increment on every cycle out of reset.
REQ-024 stall_cnt_o SHALL increment on each cycle with fetch_valid_i & !ctl_id_allow_in_o.
REQ-025 retire_cnt_o SHALL increment on each cycle with ctl_wb_over_o & !exc_flush_i.
REQ-026 Every counter SHALL wrap from 2^CNT_W-1 to 0 without saturating or raising a flag.

Reset
REQ-027 With rstn_i low, all valid flops and counters SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 Consequently during reset every ctl_*_over_o except ctl_if_over_o SHALL be 0, and every ctl_*_allow_in_o SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight instructions; there SHALL be no flush side effects after release.
REQ-030 The first edge after rstn_i rises SHALL be an ordinary operating cycle.

Verification
REQ-031 Streaming: all readies 1, fetch_valid_i 1 for 10 cycles -> wb_valid_o rises at cycle 4 after the first fetch, and retire_cnt_o = 6 after cycle 10.
REQ-032 MEM back-pressure: mem_ready_i low 3 cycles with ID/EX/MEM full -> allow_in for ID/EX/MEM low throughout, stall_cnt_o +3, no valid lost or duplicated, and flow resumes the cycle mem_ready_i rises.
REQ-033 Branch: br_flush_i pulsed with v_id=1, v_ex=1 -> next cycle id_valid_o=0, ex instruction proceeds to MEM, and no new ID entry is created that cycle.
REQ-034 Exception: exc_flush_i with all stages valid -> next cycle id/ex/mem_valid_o=0, retire_cnt_o unchanged, and WB empties if wb_ready_i=1.
REQ-035 Simultaneous flushes and a mid-run asynchronous reset (rstn_i low between edges) -> exc precedence observed, and valids/counters read 0 before the next edge.
REQ-036 Counter wrap: force CNT_W=4 and run 17 cycles -> cycle_cnt_o reads 1.
